// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round datapath helpers.
// Byte type, default reduction polynomial and GF multiplier FSM states.
package aes_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } gf_state_t;

  // Number of BUSY cycles needed to consume an 8-bit coefficient.
  function automatic int gf_steps(input int bits_per_cycle);
    return 8 / bits_per_cycle;
  endfunction

endpackage

// File: rtl/gf_mult_iter_if.sv
// Operand/product handshake bundle between the round state and the mix network.
// The multiplier is the slave; the round-state side is the master.
interface gf_mult_iter_if #(
  parameter int LANES = 4
);

  logic                 in_valid;
  logic                 in_ready;
  logic [8*LANES-1:0]   operand;
  logic [8*LANES-1:0]   coeff;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*LANES-1:0]   product;

  modport master (
    output in_valid, operand, coeff, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, operand, coeff, out_ready,
    output in_ready, out_valid, product
  );

endinterface

// File: rtl/gf_mult_iter_step.sv
// One shift-and-add step of an LSB-first GF(2^8) multiply.
// Purely combinational; chained BITS_PER_CYCLE deep per lane by the top.
module gf_mult_step
  import aes_pkg::*;
#(
  parameter byte_t POLY = AES_POLY
) (
  input  byte_t a,
  input  byte_t b,
  input  byte_t acc,
  output byte_t a_nxt,
  output byte_t b_nxt,
  output byte_t acc_nxt
);

  assign acc_nxt = acc ^ (b[0] ? a : 8'h00);
  assign a_nxt   = {a[6:0], 1'b0} ^ (a[7] ? POLY : 8'h00);
  assign b_nxt   = {1'b0, b[7:1]};

endmodule

// File: rtl/gf_mult_iter.sv
// Iterative multi-lane GF(2^8) multiplier, arbitrary coefficient per lane.
// Lanes run lock-step under one FSM; BITS_PER_CYCLE steps are unrolled per cycle.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for an operand set
//   BUSY  | shifting coefficient bits through the step chain
//   DONE  | product held with out_valid until out_ready
module gf_mult_iter
  import aes_pkg::*;
#(
  parameter int    LANES          = 4,
  parameter int    BITS_PER_CYCLE = 1,
  parameter byte_t POLY           = AES_POLY
) (
  input  logic          clk,
  input  logic          n_rst,
  gf_mult_iter_if.slave bus
);

  localparam int N  = gf_steps(BITS_PER_CYCLE);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  gf_state_t state_q, state_d;
  logic      load, step, finish;

  logic [CW-1:0]         cnt_q;
  byte_t [LANES-1:0]     a_q, b_q, acc_q, prod_q;
  byte_t [LANES-1:0]     a_nx, b_nx, acc_nx;

  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cnt_q == CNT_LAST) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.product   = prod_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    byte_t a_ch   [BITS_PER_CYCLE+1];
    byte_t b_ch   [BITS_PER_CYCLE+1];
    byte_t acc_ch [BITS_PER_CYCLE+1];

    assign a_ch[0]   = a_q[l];
    assign b_ch[0]   = b_q[l];
    assign acc_ch[0] = acc_q[l];

    for (genvar s = 0; s < BITS_PER_CYCLE; s++) begin : g_step
      gf_mult_step #(
        .POLY (POLY)
      ) u_step (
        .a       (a_ch[s]),
        .b       (b_ch[s]),
        .acc     (acc_ch[s]),
        .a_nxt   (a_ch[s+1]),
        .b_nxt   (b_ch[s+1]),
        .acc_nxt (acc_ch[s+1])
      );
    end

    assign a_nx[l]   = a_ch[BITS_PER_CYCLE];
    assign b_nx[l]   = b_ch[BITS_PER_CYCLE];
    assign acc_nx[l] = acc_ch[BITS_PER_CYCLE];
  end

  // Counter is cleared on every accept, so it never needs to wrap.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      a_q   <= bus.operand;
      b_q   <= bus.coeff;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (step) begin
      a_q   <= a_nx;
      b_q   <= b_nx;
      acc_q <= acc_nx;
      if (finish) prod_q <= acc_nx;
      else        cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: doc/gf_mult_iter.md
Name: gf_mult_iter

Overview:
- Iterative multi-lane GF(2^8) multiplier: each lane multiplies an 8-bit operand by an arbitrary 8-bit coefficient modulo a parametrised reduction polynomial.
- Generalises the fixed multiply-by-02 used in MixColumns to any coefficient, so inverse MixColumns (09/0B/0D/0E) and key-schedule products share one engine.
- Sits between the round state register and the MixColumns/InvMixColumns XOR network, with a valid/ready handshake on both sides.

Parameters:
- LANES, 4, number of independent byte lanes (4 = one state column).
- BITS_PER_CYCLE, 1, coefficient bits consumed per BUSY cycle; legal values 1, 2, 4, 8.
- POLY, 8'h1B, low 8 bits of the reduction polynomial (x^8 implied).

Ports:
- clk  input  1  system clock.
- n_rst  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept a new operand set.
- operand  input  8*LANES  lane i operand in bits [8i+7:8i].
- coeff  input  8*LANES  lane i coefficient in bits [8i+7:8i].
- out_valid  output  1  product is valid and held.
- out_ready  input  1  consumer accepts the product.
- product  output  8*LANES  lane i product in bits [8i+7:8i].

Behaviour:
- Reset (n_rst low at a clk edge) forces the following. Reset wins over every other input, including mid-BUSY and mid-DONE; any in-flight operation is discarded with no out_valid.
  - state = IDLE, in_ready = 1, out_valid = 0.
  - product = 0, internal a/b/acc registers = 0, counter = 0.
- Constant N = 8/BITS_PER_CYCLE.
- FSM states:
  - IDLE: in_ready = 1. On in_valid, per lane load a = operand, b = coeff, acc = 0; set cnt = 0 and go to BUSY.
  - BUSY: in_ready = 0, out_valid = 0. Each cycle performs BITS_PER_CYCLE unrolled steps per lane, LSB-first:
    - acc ^= (b[0] ? a : 0)
    - a = xtime(a), where xtime(a) = {a[6:0],1'b0} ^ (a[7] ? POLY : 0)
    - b = b >> 1
    - After the steps, cnt++. When cnt == N-1, the same edge writes the final acc into product and goes to DONE.
  - DONE: out_valid = 1; product holds stable while out_ready = 0. On out_ready, go to IDLE at that edge; out_valid drops and in_ready rises the next cycle.
- Latency: the accept edge is cycle 0; out_valid is high from cycle N. Throughput is one operand set per N+2 cycles with out_ready tied high.
- Inputs are ignored outside IDLE, and operand/coeff are sampled only on the accept edge.
- product keeps its last value after the DONE->IDLE transition; it is meaningful only while out_valid = 1.
- Boundary conditions:
  - coeff = 0 gives product 0.
  - coeff = 1 gives product = operand.
  - operand = 0 gives 0.
  - BITS_PER_CYCLE = 8 gives N = 1: one BUSY cycle.
  - All lanes are lock-step, sharing the FSM and counter.
- Counter width is $clog2(N) bits, with a minimum of 1. No wrap: the counter is reset on every accept.

Decomposition:
- Shared package aes_pkg contains:
  - byte_t typedef (logic [7:0]).
  - AES_POLY = 8'h1B.
  - gf_state_t enum {IDLE, BUSY, DONE}.
- Sub-module gf_mult_step: combinational, parameter POLY. Inputs a, b, acc; outputs the next a, b and acc for one bit step.
- gf_mult_iter instantiates LANES × BITS_PER_CYCLE gf_mult_step instances via generate, chained within each lane.

Test Plan:
- FIPS-197 product, BITS_PER_CYCLE=1, LANES=4: operands 57/57/57/57 with coeffs 83/13/02/01 → product lanes C1/FE/AE/57. out_valid rises exactly 8 cycles after accept.
- Inverse coefficients: operand 57 with coeffs 0E/0B/0D/09 → lanes 67/??-free check by golden model. Overflow: FF×02 → E5. Zero: 00×FF → 00, and FF×00 → 00.
- BITS_PER_CYCLE=4 and 8 builds rerun the first scenario → identical products; out_valid at cycles 2 and 1 respectively.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → product stable, in_ready=0 throughout. Toggling in_valid/operand during BUSY/DONE changes nothing.
- Reset mid-BUSY (n_rst low at cycle 3) → next cycle state IDLE, in_ready=1, out_valid=0, product=0. Assert no out_valid ever appears for the aborted set.
- Random soak: 10k random operand/coeff sets with random out_ready → all lanes match the reference GF(2^8) model.
